// File: rtl/opcode_executor.sv
// Purpose : runs each newly presented 16-bit opcode once (echo, reg write, reg read, 4-bit ALU op)
//           against a 16x4 register file and drives the 7-seg display value and ALU flags.
// Latency : ECHO/READ/WRITE results land on the edge leaving DECODE; ALU results five edges after acceptance.
// Backpressure: Busy high outside IDLE; opcode changes while busy are dropped, only the value
//           present on return to IDLE is compared against the last accepted opcode.
// Ports   : CLK_In/RSTn_In clock and async active-low reset; Opcode command input; Busy executing;
//           Disp_Value {left,right} digits; Flag_C/Flag_Z flags of the last ALU op;
//           Seg_Out {left,right} active-low segments g..a, present only when SEG7_DECODE_EN is defined.
module opcode_executor #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic        CLK_In,
    input  logic        RSTn_In,
    input  logic [15:0] Opcode,
    output logic        Busy,
    output logic [7:0]  Disp_Value,
    output logic        Flag_C,
`ifdef SEG7_DECODE_EN
    output logic        Flag_Z,
    output logic [13:0] Seg_Out
`else
    output logic        Flag_Z
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_RD_A, S_RD_B, S_EXEC, S_WB, S_DONE
    } state_t;

    state_t              state_q;
    logic [15:0]         op_q;
    logic [15:0]         last_q;
    logic [DATA_W-1:0]   regs_q [2**ADDR_W];
    logic [DATA_W-1:0]   a_q, b_q, res_q;
    logic                c_q;
    logic                busy_q;
    logic [7:0]          disp_q;
    logic                flag_c_q, flag_z_q;

    // Field views of the latched opcode
    logic [3:0]          alu_op;
    logic [ADDR_W-1:0]   src_a, src_b, dst;
    logic                is_nop;
    assign alu_op = op_q[15:12];
    assign src_a  = op_q[11:8];
    assign src_b  = op_q[7:4];
    assign dst    = op_q[3:0];
    assign is_nop = (alu_op >= 4'd10);

    // ALU on the operands captured in RD_A/RD_B
    logic [DATA_W-1:0]   alu_res_d;
    logic                alu_c_d;
    logic [DATA_W:0]     sum_w, diff_w;
    assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_w = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        case (alu_op)
            4'd1: begin alu_res_d = sum_w[DATA_W-1:0];  alu_c_d = sum_w[DATA_W];  end
            4'd2: begin alu_res_d = diff_w[DATA_W-1:0]; alu_c_d = diff_w[DATA_W]; end
            4'd3: alu_res_d = a_q & b_q;
            4'd4: alu_res_d = a_q | b_q;
            4'd5: alu_res_d = a_q ^ b_q;
            4'd6: alu_res_d = ~a_q;
            4'd7: begin alu_res_d = {a_q[DATA_W-2:0], 1'b0}; alu_c_d = a_q[DATA_W-1]; end
            4'd8: begin alu_res_d = {1'b0, a_q[DATA_W-1:1]}; alu_c_d = a_q[0];        end
            4'd9: alu_res_d = a_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_In or negedge RSTn_In) begin
        if (!RSTn_In) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            last_q   <= 16'hFFFF;   // guarantees the first opcode after reset is seen as new
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            disp_q   <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Opcode != last_q) begin
                        op_q    <= Opcode;
                        last_q  <= Opcode;
                        busy_q  <= 1'b1;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (alu_op != 4'd0) begin
                        state_q <= S_RD_A;
                    end else begin
                        state_q <= S_DONE;
                        if (op_q[0]) begin
                            regs_q[op_q[4:1]] <= op_q[11:8];
                            disp_q            <= {op_q[4:1], op_q[11:8]};
                        end else if (op_q[7:5] == 3'b001) begin
                            disp_q <= {4'h0, op_q[11:8]};
                        end else begin
                            disp_q <= {op_q[11:8], regs_q[op_q[11:8]]};
                        end
                    end
                end
                S_RD_A: begin
                    a_q     <= regs_q[src_a];
                    state_q <= S_RD_B;
                end
                S_RD_B: begin
                    b_q     <= regs_q[src_b];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    res_q   <= alu_res_d;
                    c_q     <= alu_c_d;
                    state_q <= S_WB;
                end
                S_WB: begin
                    // NOP codes still walk the full ALU path but leave state untouched
                    if (!is_nop) begin
                        regs_q[dst] <= res_q;
                        disp_q      <= {dst, res_q};
                        flag_c_q    <= c_q;
                        flag_z_q    <= (res_q == '0);
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy       = busy_q;
    assign Disp_Value = disp_q;
    assign Flag_C     = flag_c_q;
    assign Flag_Z     = flag_z_q;

`ifdef SEG7_DECODE_EN
    // Active-high g..a pattern for one hex digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
        endcase
    endfunction

    logic [13:0] seg_q;
    always_ff @(posedge CLK_In or negedge RSTn_In) begin
        if (!RSTn_In) seg_q <= 14'h3FFF;
        else          seg_q <= ~{seg7(disp_q[7:4]), seg7(disp_q[3:0])};
    end
    assign Seg_Out = seg_q;
`endif

endmodule

// File: tb/tb_opcode_executor.sv
// Purpose : scoreboard bench for opcode_executor; a reference model predicts Disp/flags per accepted opcode.
// Latency : compares once Busy falls after each accepted opcode.
// Backpressure: Opcode is only changed while busy in the dedicated drop-while-busy scenario.
module tb_opcode_executor;

    logic        clk;
    logic        rst_n;
    logic [15:0] opcode;
    logic        busy;
    logic [7:0]  disp;
    logic        flag_c, flag_z;
`ifdef SEG7_DECODE_EN
    logic [13:0] seg_out;
`endif

    opcode_executor dut (
        .CLK_In     (clk),
        .RSTn_In    (rst_n),
        .Opcode     (opcode),
        .Busy       (busy),
        .Disp_Value (disp),
        .Flag_C     (flag_c),
`ifdef SEG7_DECODE_EN
        .Flag_Z     (flag_z),
        .Seg_Out    (seg_out)
`else
        .Flag_Z     (flag_z)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] disp;
        logic       c;
        logic       z;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // Reference model state
    logic [3:0]  m_regs [16];
    logic [15:0] m_last;
    logic [7:0]  m_disp;
    logic        m_c, m_z;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 4'h0;
        m_last = 16'hFFFF;
        m_disp = 8'h00;
        m_c    = 1'b0;
        m_z    = 1'b0;
    endtask

    // Predicts one accepted opcode and pushes the resulting outputs
    task automatic model_op(input logic [15:0] op);
        int a, b, r, s;
        logic c;
        exp_t e;
        if (op == m_last) return;
        m_last = op;
        if (op[15:12] != 4'h0) begin
            a = int'(m_regs[op[11:8]]);
            b = int'(m_regs[op[7:4]]);
            r = 0;
            c = 1'b0;
            case (op[15:12])
                4'd1: begin s = a + b; r = s % 16; c = (s >= 16); end
                4'd2: begin r = (a - b + 16) % 16; c = (a < b); end
                4'd3: r = a & b;
                4'd4: r = a | b;
                4'd5: r = a ^ b;
                4'd6: r = 15 - a;
                4'd7: begin r = (a * 2) % 16; c = (a >= 8); end
                4'd8: begin r = a / 2; c = (a % 2 == 1); end
                4'd9: r = a;
                default: r = -1;
            endcase
            if (r >= 0) begin
                m_regs[op[3:0]] = r[3:0];
                m_disp = {op[3:0], r[3:0]};
                m_c    = c;
                m_z    = (r == 0);
            end
        end else if (op[0]) begin
            m_regs[op[4:1]] = op[11:8];
            m_disp = {op[4:1], op[11:8]};
        end else if (op[7:5] == 3'b001) begin
            m_disp = {4'h0, op[11:8]};
        end else begin
            m_disp = {op[11:8], m_regs[op[11:8]]};
        end
        e.disp = m_disp;
        e.c    = m_c;
        e.z    = m_z;
        sb_q.push_back(e);
    endtask

    // Waits (bounded) for one execution to start and finish, then pops and compares
    task automatic wait_done(input string tag, output int cycles);
        bit   seen;
        exp_t e;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
        if (seen) begin
            cycles = 1;
            for (int i = 0; i < 50 && busy; i++) begin
                @(negedge clk);
                if (busy) cycles++;
            end
            check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        end
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_disp"}, 32'(disp),   32'(e.disp));
            check({tag, "_c"},    32'(flag_c), 32'(e.c));
            check({tag, "_z"},    32'(flag_z), 32'(e.z));
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] op);
        int cyc;
        @(negedge clk);
        opcode = op;
        model_op(op);
        wait_done(tag, cyc);
    endtask

    // Holds the current opcode and counts cycles with Busy asserted
    task automatic hold_quiet(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst_n  = 1'b0;
        opcode = 16'hFFFF;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy),   32'd0);
        check("rst_disp", 32'(disp),   32'd0);
        check("rst_c",    32'(flag_c), 32'd0);
        check("rst_z",    32'(flag_z), 32'd0);
        rst_n = 1'b1;
        hold_quiet("rst_no_accept_ffff", 3);

        // Echo: busy for exactly two cycles
        @(negedge clk);
        opcode = 16'h0020;
        model_op(16'h0020);
        wait_done("echo0", cyc);
        check("echo0_busy_cycles", 32'(cyc), 32'd2);
        run_op("echo5", 16'h0520);

        // Write r3=A, held: executes once
        run_op("wr_r3", 16'h0A27);
        hold_quiet("wr_r3_held", 18);

        // ALU add with carry, then sub giving zero
        run_op("wr_r1", 16'h0503);
        run_op("wr_r2", 16'h0C05);
        run_op("add", 16'h1124);
        run_op("sub_zero", 16'h2113);
        hold_quiet("sub_held", 10);

        // Remaining op codes r1 op r2 -> r6, including a NOP
        for (int k = 3; k <= 10; k++) begin
            logic [3:0] kk;
            kk = 4'(k);
            run_op($sformatf("alu_op%0d", k), {kk, 4'h1, 4'h2, 4'h6});
        end
        run_op("sub_borrow", 16'h2217);
        run_op("add_alias", 16'h1111);
        run_op("shr", 16'h8111);
        run_op("shl", 16'h7222);
        run_op("rd_r4", 16'h0400);
        run_op("rd_r3", 16'h0300);
        run_op("rd_r6", 16'h0600);
        run_op("rd_r4b", 16'h0400);

        // Opcode churns while busy: only the value held at IDLE return runs
        @(negedge clk);
        opcode = 16'h9106;
        model_op(16'h9106);
        @(negedge clk);
        check("churn_busy", 32'(busy), 32'd1);
        opcode = 16'h0F03;
        @(negedge clk);
        opcode = 16'h0F05;
        @(negedge clk);
        opcode = 16'h0F07;
        @(negedge clk);
        opcode = 16'h0200;
        model_op(16'h0200);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        begin
            exp_t e;
            check("churn_first_done", 32'(busy), 32'd0);
            e = sb_q.pop_front();
            check("churn_first_disp", 32'(disp), 32'(e.disp));
        end
        wait_done("churn_final", cyc);
        run_op("churn_rd_r1", 16'h0100);

        // Reset in ALU EXEC
        @(negedge clk);
        opcode = 16'h1114;
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n  = 1'b0;
        opcode = 16'h0100;
        #1;
        check("midrst_busy", 32'(busy),   32'd0);
        check("midrst_disp", 32'(disp),   32'd0);
        check("midrst_c",    32'(flag_c), 32'd0);
        check("midrst_z",    32'(flag_z), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_op(16'h0100);
        wait_done("midrst_rd_r1", cyc);
        run_op("midrst_rd_r4", 16'h0400);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
